// File: rtl/memacc_pkg.sv
// memacc_pkg: constants and helpers shared by the memory-access stage and
// its neighbours (execute, write-back).
//   - ST_*       : memacc FSM state encodings
//   - MEM_*      : ex_mem size/sign codes (loads and stores share them)
//   - ZERO_WORD  : 64-bit zero used for reset values
//   - mem_size() : access size from an ex_mem code
//   - size_mask(): unshifted byte-enable pattern for an access size
//   - addr_misaligned(): natural-alignment check on the low address bits
package memacc_pkg;

  localparam logic [63:0] ZERO_WORD = 64'h0000_0000_0000_0000;

  // FSM encodings kept as plain constants so older code can use them too.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ex_mem codes. For stores the signed/unsigned variants mean the same size.
  localparam logic [2:0] MEM_ILL = 3'b000;
  localparam logic [2:0] MEM_LB  = 3'b001;
  localparam logic [2:0] MEM_LH  = 3'b010;
  localparam logic [2:0] MEM_LW  = 3'b011;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_LWU = 3'b110;
  localparam logic [2:0] MEM_LD  = 3'b111;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  // Access size for a code; the illegal code maps to byte and is rejected
  // separately by the caller.
  function automatic mem_size_e mem_size(input logic [2:0] code);
    mem_size_e sz;
    case (code)
      MEM_LB, MEM_LBU: sz = SZ_BYTE;
      MEM_LH, MEM_LHU: sz = SZ_HALF;
      MEM_LW, MEM_LWU: sz = SZ_WORD;
      MEM_LD:          sz = SZ_DWORD;
      default:         sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  // Byte enables for an access at offset 0.
  function automatic logic [7:0] size_mask(input mem_size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_BYTE:  m = 8'h01;
      SZ_HALF:  m = 8'h03;
      SZ_WORD:  m = 8'h0F;
      SZ_DWORD: m = 8'hFF;
      default:  m = 8'h00;
    endcase
    return m;
  endfunction

  // An access is aligned when its offset is a multiple of its size.
  function automatic logic addr_misaligned(input mem_size_e sz,
                                           input logic [2:0] off);
    logic bad;
    case (sz)
      SZ_BYTE:  bad = 1'b0;
      SZ_HALF:  bad = off[0];
      SZ_WORD:  bad = |off[1:0];
      SZ_DWORD: bad = |off;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memacc_align.sv
// memacc_align: purely combinational lane steering for memacc.
// Ports:
//   mem_i      [2:0]  size/sign code of the op being offered
//   addr_lo_i  [2:0]  byte offset of the op being offered
//   wdata_i    [63:0] right-justified store data of the op being offered
//   rd_off_i   [2:0]  byte offset of the load waiting for data
//   rdata_i    [63:0] aligned read doubleword from the bus
//   misalign_o        op is illegal or not naturally aligned
//   wmask_o    [7:0]  byte enables placed at the op's offset
//   wdata_o    [63:0] store data moved to the op's byte lanes
//   rdata_o    [63:0] read data right-justified for write-back
module memacc_align
  import memacc_pkg::*;
(
  input  logic [2:0]  mem_i,
  input  logic [2:0]  addr_lo_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  rd_off_i,
  input  logic [63:0] rdata_i,
  output logic        misalign_o,
  output logic [7:0]  wmask_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  mem_size_e sz_s;

  // Alignment check and lane shifts; shift amounts are offset*8 bits.
  always_comb begin
    sz_s       = mem_size(mem_i);
    misalign_o = (mem_i == MEM_ILL) | addr_misaligned(sz_s, addr_lo_i);
    // Aligned ops never shift enables past bit 7, so truncation is safe.
    wmask_o    = size_mask(sz_s) << addr_lo_i;
    wdata_o    = wdata_i << {addr_lo_i, 3'b000};
    rdata_o    = rdata_i >> {rd_off_i, 3'b000};
  end

endmodule

// File: rtl/memacc.sv
// memacc: memory-access stage between execute and write-back.
// Accepts one load/store from execute, rejects illegal or misaligned ops,
// issues a valid/ready data-bus request, waits for load data and hands the
// right-justified doubleword plus its load code to write-back.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid/ex_ready            execute handshake (ready only in IDLE)
//   ex_we, ex_mem, ex_addr,
//   ex_wdata                     op kind, size code, byte address, store data
//   dbus_req/dbus_ready          bus request handshake
//   dbus_we, dbus_addr,
//   dbus_wdata, dbus_wmask       request payload (held stable while pending)
//   dbus_rvalid, dbus_rdata      load return
//   mem_r_data, mem              last completed load data and code
//   wb_ena, mem_done, misalign   single-cycle completion pulses
module memacc
  import memacc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic [2:0]  ex_mem,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  output logic        dbus_req,
  input  logic        dbus_ready,
  output logic        dbus_we,
  output logic [63:0] dbus_addr,
  output logic [63:0] dbus_wdata,
  output logic [7:0]  dbus_wmask,
  input  logic        dbus_rvalid,
  input  logic [63:0] dbus_rdata,
  output logic [63:0] mem_r_data,
  output logic [2:0]  mem,
  output logic        wb_ena,
  output logic        mem_done,
  output logic        misalign
);

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  code_q, code_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] mem_r_data_q, mem_r_data_d;
  logic [2:0]  mem_q, mem_d;
  logic        wb_ena_q, wb_ena_d;
  logic        mem_done_q, mem_done_d;
  logic        misalign_q, misalign_d;

  logic        al_misalign_s;
  logic [7:0]  al_wmask_s;
  logic [63:0] al_wdata_s;
  logic [63:0] al_rdata_s;
  logic        accept_s;

  // Store lanes and the misalign check are computed from the incoming op so
  // the bus payload can be registered at accept; the read shift uses the
  // offset latched with the pending load.
  memacc_align u_align (
    .mem_i      (ex_mem),
    .addr_lo_i  (ex_addr[2:0]),
    .wdata_i    (ex_wdata),
    .rd_off_i   (addr_q[2:0]),
    .rdata_i    (dbus_rdata),
    .misalign_o (al_misalign_s),
    .wmask_o    (al_wmask_s),
    .wdata_o    (al_wdata_s),
    .rdata_o    (al_rdata_s)
  );

  // Execute may hand over an op only while idle and out of reset.
  assign ex_ready = (state_q == ST_IDLE) && !rst;
  assign accept_s = ex_valid && ex_ready;

  // Next-state and next-output logic for the IDLE/REQ/WAIT sequence.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    code_d       = code_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    mem_r_data_d = mem_r_data_q;
    mem_d        = mem_q;
    wb_ena_d     = 1'b0;
    mem_done_d   = 1'b0;
    misalign_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d    = ex_we;
          code_d  = ex_mem;
          addr_d  = ex_addr;
          wdata_d = al_wdata_s;
          wmask_d = al_wmask_s;
          if (al_misalign_s) begin
            // Rejected ops finish immediately without touching the bus.
            misalign_d = 1'b1;
            mem_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d    = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (dbus_ready) begin
          if (we_q) begin
            mem_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d    = ST_WAIT;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_WAIT: begin
        if (dbus_rvalid) begin
          mem_r_data_d = al_rdata_s;
          mem_d        = code_q;
          wb_ena_d     = 1'b1;
          mem_done_d   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      code_q       <= MEM_ILL;
      addr_q       <= ZERO_WORD;
      wdata_q      <= ZERO_WORD;
      wmask_q      <= 8'h00;
      mem_r_data_q <= ZERO_WORD;
      mem_q        <= MEM_ILL;
      wb_ena_q     <= 1'b0;
      mem_done_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      code_q       <= code_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      mem_r_data_q <= mem_r_data_d;
      mem_q        <= mem_d;
      wb_ena_q     <= wb_ena_d;
      mem_done_q   <= mem_done_d;
      misalign_q   <= misalign_d;
    end
  end

  // Bus payload comes straight from registers, so it cannot change while
  // a request is pending.
  assign dbus_req   = (state_q == ST_REQ);
  assign dbus_we    = we_q;
  assign dbus_addr  = {addr_q[63:3], 3'b000};
  assign dbus_wdata = wdata_q;
  assign dbus_wmask = wmask_q;

  assign mem_r_data = mem_r_data_q;
  assign mem        = mem_q;
  assign wb_ena     = wb_ena_q;
  assign mem_done   = mem_done_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_memacc.sv
module tb_memacc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_we;
  logic [2:0]  ex_mem;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic        dbus_req;
  logic        dbus_ready;
  logic        dbus_we;
  logic [63:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wmask;
  logic        dbus_rvalid;
  logic [63:0] dbus_rdata;
  logic [63:0] mem_r_data;
  logic [2:0]  mem;
  logic        wb_ena;
  logic        mem_done;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // reference state: last completed load as write-back should see it
  logic [63:0] exp_rd;
  logic [2:0]  exp_mem;

  // bus payload observed at the first request cycle of the latest op
  logic [7:0]  cap_wmask;
  logic [63:0] cap_wdata;
  logic [63:0] cap_addr;

  memacc dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_we       (ex_we),
    .ex_mem      (ex_mem),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .dbus_req    (dbus_req),
    .dbus_ready  (dbus_ready),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_wdata  (dbus_wdata),
    .dbus_wmask  (dbus_wmask),
    .dbus_rvalid (dbus_rvalid),
    .dbus_rdata  (dbus_rdata),
    .mem_r_data  (mem_r_data),
    .mem         (mem),
    .wb_ena      (wb_ena),
    .mem_done    (mem_done),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3, 3'd6: return 4;
      3'd7:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_mask(input logic [2:0] c, input int off);
    logic [7:0] m;
    int sz;
    sz = size_bytes(c);
    m = 8'h00;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + sz) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bytes_to_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = m[b] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // store byte k of the data lands in bus lane off+k
  function automatic logic [63:0] exp_wdata(input logic [63:0] d, input int off);
    logic [63:0] r;
    r = 64'd0;
    for (int b = 0; b < 8; b++)
      if (b >= off) r[b*8 +: 8] = d[(b-off)*8 +: 8];
    return r;
  endfunction

  // result byte i comes from bus lane off+i; lanes past 7 read as zero
  function automatic logic [63:0] exp_load(input logic [63:0] d, input int off);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i + off < 8) r[i*8 +: 8] = d[(i+off)*8 +: 8];
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with bus delays, checked cycle by cycle.
  task automatic do_op(input logic we, input logic [2:0] code, input logic [63:0] addr,
                       input logic [63:0] wd, input int rdy_dly, input int rv_dly,
                       input logic [63:0] rd);
    int off;
    int sz;
    bit bad;
    logic [7:0]  em;
    logic [63:0] bm;
    logic [63:0] ea;
    off = int'(addr[2:0]);
    sz  = size_bytes(code);
    bad = (sz == 0) || ((off % sz) != 0);
    ea  = addr & ~64'd7;

    check("ready_idle", ex_ready, 64'd1);
    ex_valid = 1'b1; ex_we = we; ex_mem = code; ex_addr = addr; ex_wdata = wd;
    tick;
    // scramble inputs so any failure to latch shows up
    ex_valid = 1'b0; ex_we = ~we; ex_mem = 3'($urandom);
    ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};

    if (bad) begin
      check("mis_flag", misalign, 64'd1);
      check("mis_done", mem_done, 64'd1);
      check("mis_req", dbus_req, 64'd0);
      check("mis_ready", ex_ready, 64'd1);
      check("mis_wb", wb_ena, 64'd0);
      tick;
      check("mis_pulse", {misalign, mem_done}, 64'd0);
      check("mis_req2", dbus_req, 64'd0);
      check("mis_rd_hold", mem_r_data, exp_rd);
    end else begin
      em = exp_mask(code, off);
      bm = bytes_to_bits(em);
      cap_wmask = dbus_wmask; cap_wdata = dbus_wdata; cap_addr = dbus_addr;
      check("req", dbus_req, 64'd1);
      check("busy", ex_ready, 64'd0);
      check("addr", dbus_addr, ea);
      check("we", dbus_we, we);
      check("wmask", dbus_wmask, em);
      if (we) check("wdata", dbus_wdata & bm, exp_wdata(wd, off) & bm);
      for (int k = 0; k < rdy_dly; k++) begin
        dbus_ready = 1'b0;
        tick;
        check("hold_req", dbus_req, 64'd1);
        check("hold_addr", dbus_addr, ea);
        check("hold_we", dbus_we, we);
        check("hold_wmask", dbus_wmask, em);
        if (we) check("hold_wdata", dbus_wdata & bm, exp_wdata(wd, off) & bm);
      end
      dbus_ready = 1'b1;
      tick;
      dbus_ready = 1'b0;
      if (we) begin
        check("st_done", mem_done, 64'd1);
        check("st_req", dbus_req, 64'd0);
        check("st_ready", ex_ready, 64'd1);
        check("st_wb", wb_ena, 64'd0);
        check("st_rd_hold", mem_r_data, exp_rd);
        check("st_mem_hold", mem, exp_mem);
        tick;
        check("st_pulse", mem_done, 64'd0);
      end else begin
        check("wait_req", dbus_req, 64'd0);
        check("wait_busy", ex_ready, 64'd0);
        check("wait_done", mem_done, 64'd0);
        for (int j = 0; j < rv_dly; j++) begin
          tick;
          check("wait_nowb", wb_ena, 64'd0);
        end
        dbus_rvalid = 1'b1; dbus_rdata = rd;
        tick;
        dbus_rvalid = 1'b0; dbus_rdata = {$urandom, $urandom};
        exp_rd  = exp_load(rd, off);
        exp_mem = code;
        check("wb_ena", wb_ena, 64'd1);
        check("ld_done", mem_done, 64'd1);
        check("ld_data", mem_r_data, exp_rd);
        check("ld_mem", mem, exp_mem);
        check("ld_ready", ex_ready, 64'd1);
        tick;
        check("ld_pulse", {wb_ena, mem_done}, 64'd0);
        check("ld_hold", mem_r_data, exp_rd);
        check("ld_mem_hold", mem, exp_mem);
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic        r_we;
    logic [2:0]  r_code;
    logic [63:0] r_addr;
    int          r_sz;
    int          r_lo;

    rst = 1'b1; ex_valid = 1'b1; ex_we = 1'b0; ex_mem = 3'b111;
    ex_addr = 64'h1000; ex_wdata = 64'd0;
    dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 64'd0;
    exp_rd = 64'd0; exp_mem = 3'b000;
    repeat (3) tick;

    // reset state (ex_valid held high must not be taken)
    check("rst_ready", ex_ready, 64'd0);
    check("rst_req", dbus_req, 64'd0);
    check("rst_rdata", mem_r_data, 64'd0);
    check("rst_mem", mem, 64'd0);
    check("rst_pulses", {wb_ena, mem_done, misalign}, 64'd0);
    ex_valid = 1'b0;
    rst = 1'b0;
    tick;
    check("post_rst_ready", ex_ready, 64'd1);
    check("post_rst_req", dbus_req, 64'd0);

    // ld aligned
    do_op(1'b0, 3'b111, 64'h1000, 64'd0, 0, 1, 64'h8877665544332211);
    check("ld_aligned", mem_r_data, 64'h8877665544332211);
    check("ld_aligned_mem", mem, 64'd7);

    // lb at offset 3
    do_op(1'b0, 3'b001, 64'h1003, 64'd0, 0, 0, 64'h000000FF44332211);
    check("lb_byte", {56'd0, mem_r_data[7:0]}, 64'h44);
    check("lb_mem", mem, 64'd1);

    // sh at offset 6
    do_op(1'b1, 3'b010, 64'h2006, 64'hBEEF, 0, 0, 64'd0);
    check("sh_wmask", cap_wmask, 64'hC0);
    check("sh_wdata", {48'd0, cap_wdata[63:48]}, 64'hBEEF);
    check("sh_addr", cap_addr, 64'h2000);
    check("sh_keep_load", mem_r_data, 64'h0000_0000_0000_FF44);

    // misaligned word, misaligned dword, illegal code
    do_op(1'b0, 3'b011, 64'h3002, 64'd0, 0, 0, 64'd0);
    do_op(1'b1, 3'b111, 64'h3004, 64'h1234, 0, 0, 64'd0);
    do_op(1'b0, 3'b000, 64'h3000, 64'd0, 0, 0, 64'd0);

    // backpressure: ready low 3 cycles
    do_op(1'b1, 3'b111, 64'h4008, 64'h0123_4567_89AB_CDEF, 3, 0, 64'd0);
    do_op(1'b0, 3'b110, 64'h4004, 64'd0, 2, 3, 64'hDEAD_BEEF_CAFE_F00D);

    // rvalid while idle is ignored
    dbus_rvalid = 1'b1; dbus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    dbus_rvalid = 1'b0;
    check("idle_rv_wb", wb_ena, 64'd0);
    check("idle_rv_done", mem_done, 64'd0);
    check("idle_rv_data", mem_r_data, exp_rd);

    // reset while waiting for load data, then a late rvalid
    ex_valid = 1'b1; ex_we = 1'b0; ex_mem = 3'b111; ex_addr = 64'h5000;
    tick;
    ex_valid = 1'b0;
    dbus_ready = 1'b1;
    tick;
    dbus_ready = 1'b0;
    check("rw_in_wait", ex_ready, 64'd0);
    rst = 1'b1;
    tick;
    check("rw_ready_in_rst", ex_ready, 64'd0);
    check("rw_req", dbus_req, 64'd0);
    check("rw_rdata", mem_r_data, 64'd0);
    check("rw_mem", mem, 64'd0);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 64'h1111_2222_3333_4444;
    tick;
    dbus_rvalid = 1'b0;
    exp_rd = 64'd0; exp_mem = 3'b000;
    check("rw_late_wb", wb_ena, 64'd0);
    check("rw_late_done", mem_done, 64'd0);
    check("rw_late_data", mem_r_data, 64'd0);
    check("rw_idle", ex_ready, 64'd1);

    // randomized ops, mostly aligned
    for (int n = 0; n < 60; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_code = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      r_sz   = size_bytes(r_code);
      r_lo   = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0 && r_sz > 0) r_lo = r_lo - (r_lo % r_sz);
      r_addr[2:0] = 3'(r_lo);
      do_op(r_we, r_code, r_addr, {$urandom, $urandom}, $urandom_range(0, 3),
            $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
